// File: rtl/uart_txrx.sv
// uart_txrx: full-duplex UART with an independent transmitter and receiver
// on a single clock. Frames are 8N1 by default (start 0, 8 data bits LSB
// first, stop 1), each bit lasting CLK clock cycles.
//
// Optional feature macro: UART_PARITY_EN
//   When defined, an even-parity bit follows data bit 7 (11-bit frames),
//   and the RX_PARITY_ERR output pulses when a received parity bit is wrong.
//
// Parameters:
//   CLK            clock cycles per serial bit (>= 4)
// Ports:
//   CLOCK          system clock, rising edge
//   RESET          synchronous active-high reset
//   TX_VALID       one-cycle load strobe, honoured only while TX is idle
//   TX_PARALLEL    byte to transmit
//   TX_SERIAL      serial output, idles high
//   DONE           one-cycle pulse in the last cycle of the TX stop bit
//   RX_SERIAL      asynchronous serial input, idles high
//   RX_VALID       one-cycle pulse when a good frame has been received
//   RX_PARALLEL    last good received byte, held between frames
//   RX_PARITY_ERR  (UART_PARITY_EN only) one-cycle pulse on parity mismatch
module uart_txrx #(
    parameter int unsigned CLK = 16
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       TX_VALID,
    input  logic [7:0] TX_PARALLEL,
    output logic       TX_SERIAL,
    output logic       DONE,
    input  logic       RX_SERIAL,
    output logic       RX_VALID,
    output logic [7:0] RX_PARALLEL
`ifdef UART_PARITY_EN
    ,
    output logic       RX_PARITY_ERR
`endif
);

    localparam int unsigned   CW       = $clog2(CLK);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK - 1);
    // Last count of the half-bit wait; START lasts (CLK-1)/2 cycles.
    localparam logic [CW-1:0] HALF_END = CW'((CLK - 1) / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t        tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_byte, tx_byte_n;
    logic          tx_serial_n;
    logic          tx_done_n;
    logic          tx_bit_end;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_byte   <= '0;
            TX_SERIAL <= 1'b1;
            DONE      <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_idx    <= tx_idx_n;
            tx_byte   <= tx_byte_n;
            TX_SERIAL <= tx_serial_n;
            DONE      <= tx_done_n;
        end
    end

    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt;
        tx_idx_n    = tx_idx;
        tx_byte_n   = tx_byte;
        tx_serial_n = 1'b1;
        tx_bit_end  = (tx_cnt == BIT_END);

        if (tx_state != IDLE) begin
            tx_cnt_n = tx_bit_end ? '0 : tx_cnt + 1'b1;
        end

        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                if (TX_VALID) begin
                    tx_byte_n  = TX_PARALLEL;
                    tx_state_n = START;
                end
            end
            START: begin
                if (tx_bit_end) begin
                    tx_idx_n   = '0;
                    tx_state_n = DATA;
                end
            end
            DATA: begin
                if (tx_bit_end) begin
                    tx_idx_n = tx_idx + 1'b1;
                    if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_n = PARITY;
`else
                        tx_state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tx_bit_end) begin
                    tx_state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tx_bit_end) begin
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase

        // Serial line and DONE are registered from the next-state values so
        // they line up with the state they describe without output glitches.
        case (tx_state_n)
            START:   tx_serial_n = 1'b0;
            DATA:    tx_serial_n = tx_byte_n[tx_idx_n];
`ifdef UART_PARITY_EN
            PARITY:  tx_serial_n = ^tx_byte_n;
`endif
            default: tx_serial_n = 1'b1;
        endcase

        tx_done_n = (tx_state_n == STOP) && (tx_cnt_n == BIT_END);
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]    rx_sync;
    logic          rx_s;
    state_t        rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_brk, rx_brk_n;
    logic          rx_valid_n;
    logic [7:0]    rx_data_n;
    logic          rx_frame_ok;
    logic          rx_bit_end;
`ifdef UART_PARITY_EN
    logic          rx_par_ok, rx_par_ok_n;
    logic          rx_perr_n;
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rx_sync     <= '1;
            rx_state    <= IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shift    <= '0;
            rx_brk      <= 1'b0;
            RX_VALID    <= 1'b0;
            RX_PARALLEL <= '0;
`ifdef UART_PARITY_EN
            rx_par_ok     <= 1'b0;
            RX_PARITY_ERR <= 1'b0;
`endif
        end else begin
            rx_sync     <= {rx_sync[0], RX_SERIAL};
            rx_state    <= rx_state_n;
            rx_cnt      <= rx_cnt_n;
            rx_idx      <= rx_idx_n;
            rx_shift    <= rx_shift_n;
            rx_brk      <= rx_brk_n;
            RX_VALID    <= rx_valid_n;
            RX_PARALLEL <= rx_data_n;
`ifdef UART_PARITY_EN
            rx_par_ok     <= rx_par_ok_n;
            RX_PARITY_ERR <= rx_perr_n;
`endif
        end
    end

    assign rx_s = rx_sync[1];

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + 1'b1;
        rx_idx_n    = rx_idx;
        rx_shift_n  = rx_shift;
        rx_brk_n    = rx_brk;
        rx_valid_n  = 1'b0;
        rx_data_n   = RX_PARALLEL;
        rx_frame_ok = rx_s;
        rx_bit_end  = (rx_cnt == BIT_END);
`ifdef UART_PARITY_EN
        rx_par_ok_n = rx_par_ok;
        rx_perr_n   = 1'b0;
        rx_frame_ok = rx_s && rx_par_ok;
`endif

        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s) begin
                    rx_state_n = START;
                end
            end
            START: begin
                // Re-check the line at the start-bit midpoint to reject glitches.
                if (rx_cnt == HALF_END) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_idx_n   = rx_idx + 1'b1;
                    if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_n = PARITY;
`else
                        rx_state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (rx_bit_end) begin
                    rx_cnt_n    = '0;
                    rx_par_ok_n = (rx_s == ^rx_shift);
                    rx_state_n  = STOP;
                end
            end
`endif
            STOP: begin
                if (rx_brk) begin
                    // Framing error seen: hold off until the line returns high
                    // so the low stop bit is not mistaken for a new start bit.
                    rx_cnt_n = '0;
                    if (rx_s) begin
                        rx_brk_n   = 1'b0;
                        rx_state_n = IDLE;
                    end
                end else if (rx_bit_end) begin
                    rx_cnt_n = '0;
`ifdef UART_PARITY_EN
                    rx_perr_n = !rx_par_ok;
`endif
                    if (rx_frame_ok) begin
                        rx_valid_n = 1'b1;
                        rx_data_n  = rx_shift;
                    end
                    if (rx_s) begin
                        rx_state_n = IDLE;
                    end else begin
                        rx_brk_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: randomized self-checking bench for uart_txrx.
// The reference model expresses frames as plain bit vectors and received
// bytes as queues; optional UART_PARITY_EN build is covered when defined.
`timescale 1ns/1ps
module tb_uart_txrx;

    localparam int unsigned CLK = 16;
`ifdef UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CLK;

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_parallel;
    logic       tx_serial;
    logic       done;
    logic       rx_serial;
    logic       rx_valid;
    logic [7:0] rx_parallel;
`ifdef UART_PARITY_EN
    logic       rx_parity_err;
`endif
    logic       loop_en;
    logic       rx_drive;

    assign rx_serial = loop_en ? tx_serial : rx_drive;

    always #5 clock = ~clock;

    uart_txrx #(.CLK(CLK)) dut (
        .CLOCK        (clock),
        .RESET        (reset),
        .TX_VALID     (tx_valid),
        .TX_PARALLEL  (tx_parallel),
        .TX_SERIAL    (tx_serial),
        .DONE         (done),
        .RX_SERIAL    (rx_serial),
        .RX_VALID     (rx_valid),
        .RX_PARALLEL  (rx_parallel)
`ifdef UART_PARITY_EN
        ,
        .RX_PARITY_ERR(rx_parity_err)
`endif
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  rx_got[$];
    logic [7:0]  rx_exp[$];
    logic [7:0]  last_good;
    int unsigned done_cnt = 0;
    int unsigned perr_cnt = 0;

    always @(negedge clock) begin
        if (!reset && rx_valid) rx_got.push_back(rx_parallel);
        if (!reset && done) done_cnt++;
`ifdef UART_PARITY_EN
        if (!reset && rx_parity_err) perr_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole frame as a vector, bit 0 transmitted first.
    function automatic logic [NBITS-1:0] make_frame(input logic [7:0] b, input logic stop_bit,
                                                    input logic par_flip);
`ifdef UART_PARITY_EN
        return {stop_bit, (^b) ^ par_flip, b, 1'b0};
`else
        return {stop_bit, b, 1'b0} ^ {NBITS{1'b0 & par_flip}};
`endif
    endfunction

    task automatic tx_frame(input logic [7:0] b, input bit poke);
        logic [NBITS-1:0] f;
        f = make_frame(b, 1'b1, 1'b0);
        tx_valid    = 1'b1;
        tx_parallel = b;
        @(negedge clock);
        tx_valid = 1'b0;
        for (int unsigned k = 0; k < FRAME; k++) begin
            if (poke && k == 40) begin
                tx_valid    = 1'b1;
                tx_parallel = 8'h12;
            end else begin
                tx_valid = 1'b0;
            end
            check("tx_bit", tx_serial, f[k / CLK]);
            check("tx_done", done, k == FRAME - 1);
            @(negedge clock);
        end
        check("tx_idle", tx_serial, 1);
        check("tx_done_end", done, 0);
        if (loop_en) begin
            rx_exp.push_back(b);
            last_good = b;
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        logic [NBITS-1:0] f;
        f = make_frame(b, stop_bit, par_flip);
        for (int unsigned s = 0; s < NBITS; s++) begin
            rx_drive = f[s];
            repeat (CLK) @(negedge clock);
        end
        rx_drive = 1'b1;
        if (stop_bit && !par_flip) begin
            rx_exp.push_back(b);
            last_good = b;
        end
    endtask

    task automatic rx_compare();
        check("rx_count", rx_got.size(), rx_exp.size());
        while (rx_got.size() > 0 && rx_exp.size() > 0)
            check("rx_byte", rx_got.pop_front(), rx_exp.pop_front());
        rx_got.delete();
        rx_exp.delete();
        check("rx_hold", rx_parallel, last_good);
    endtask

    initial begin
        logic [7:0]  rb;
        logic        sb;
        int unsigned d0;
`ifdef UART_PARITY_EN
        int unsigned p0;
`endif
        reset       = 1'b1;
        tx_valid    = 1'b0;
        tx_parallel = 8'h00;
        rx_drive    = 1'b1;
        loop_en     = 1'b0;
        last_good   = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_tx_serial", tx_serial, 1);
        check("rst_done", done, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_parallel", rx_parallel, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // TX waveform checks with the line looped back into RX
        loop_en = 1'b1;
        repeat (2) @(negedge clock);
        tx_frame(8'hAB, 1'b0);
        tx_frame(8'h00, 1'b0);
        tx_frame(8'hFF, 1'b0);
        tx_frame(8'h55, 1'b0);
        tx_frame(8'hAB, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            tx_frame(rb, 1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clock);
        end
        repeat (CLK) @(negedge clock);
        rx_compare();

        // Directed and random RX frames from the bench
        loop_en = 1'b0;
        repeat (4) @(negedge clock);
        rx_frame(8'hE7, 1'b1, 1'b0);
        @(negedge clock);
        check("rx_e7", rx_parallel, 8'hE7);
        repeat (CLK) @(negedge clock);
        rx_compare();

        rx_drive = 1'b0;
        repeat (3) @(negedge clock);
        rx_drive = 1'b1;
        repeat (3 * CLK) @(negedge clock);
        rx_compare();

        rx_frame(8'h3C, 1'b0, 1'b0);
        repeat (CLK) @(negedge clock);
        rx_frame(8'h81, 1'b1, 1'b0);
        repeat (CLK) @(negedge clock);
        rx_compare();

        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            rx_frame(rb, sb, 1'b0);
            if (sb) repeat ($urandom_range(0, CLK)) @(negedge clock);
            else    repeat (CLK + $urandom_range(0, CLK)) @(negedge clock);
        end
        repeat (2 * CLK) @(negedge clock);
        rx_compare();

`ifdef UART_PARITY_EN
        loop_en = 1'b1;
        @(negedge clock);
        tx_frame(8'h07, 1'b0);
        repeat (CLK) @(negedge clock);
        rx_compare();
        loop_en = 1'b0;
        p0 = perr_cnt;
        rx_frame(8'h5A, 1'b1, 1'b1);
        repeat (CLK) @(negedge clock);
        rx_compare();
        check("perr_pulse", perr_cnt - p0, 1);
        rx_frame(8'h07, 1'b1, 1'b0);
        repeat (CLK) @(negedge clock);
        rx_compare();
        check("perr_none", perr_cnt - p0, 1);
`endif

        // Reset during a TX data bit aborts both directions
        loop_en = 1'b1;
        @(negedge clock);
        d0 = done_cnt;
        tx_valid    = 1'b1;
        tx_parallel = 8'h5A;
        @(negedge clock);
        tx_valid = 1'b0;
        repeat (50) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_tx_serial", tx_serial, 1);
        check("rst_mid_done", done, 0);
        check("rst_mid_rx_parallel", rx_parallel, 8'h00);
        reset = 1'b0;
        repeat (FRAME + CLK) @(negedge clock);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_no_rx", rx_got.size(), 0);
        check("rst_mid_rx_hold", rx_parallel, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
